// File: rtl/otp_token_core.sv
// Time-based one-time-code token core: second/step timebase, iterative hash job,
// serial BCD conversion and a debounced, time-limited display window on one clock.
module otp_token_core #(
    parameter int TICK_DIV = 1000000,
    parameter int STEP_SEC = 30,
    parameter int WIDTH    = 16,
    parameter int DIGITS   = 5,
    parameter int ROUNDS   = 4,
    parameter int DEBOUNCE = 1000,
    parameter int SHOW_SEC = 10
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic                  button_in,
    input  logic [WIDTH-1:0]      student_id,
    output logic [4*DIGITS-1:0]   digits_out,
    output logic                  display_on,
    output logic                  code_valid
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (STEP_SEC > 1) ? $clog2(STEP_SEC) : 1;
    localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int CW = $clog2(WIDTH);
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int TW = $clog2(SHOW_SEC + 1);
    localparam logic [4*DIGITS-1:0] BLANK = {(4*DIGITS){1'b1}};

    typedef enum logic [1:0] {
        JOB_IDLE    = 2'd0,
        JOB_HASH    = 2'd1,
        JOB_CONVERT = 2'd2,
        JOB_COMMIT  = 2'd3
    } job_state_t;

    typedef enum logic {
        DISP_OFF = 1'b0,
        DISP_ON  = 1'b1
    } disp_state_t;

    function automatic logic [WIDTH-1:0] rotl3(input logic [WIDTH-1:0] v);
        return {v[WIDTH-4:0], v[WIDTH-1:WIDTH-3]};
    endfunction

    function automatic logic [WIDTH-1:0] hash_round(input logic [WIDTH-1:0] h,
                                                     input logic [WIDTH-1:0] id,
                                                     input logic [WIDTH-1:0] step,
                                                     input logic [RW-1:0]    rnd);
        return (rotl3(h) ^ id) + step + WIDTH'(rnd);
    endfunction

    // One double-dabble step: correct every digit, then shift in the next bit.
    function automatic logic [4*DIGITS-1:0] dabble(input logic [4*DIGITS-1:0] bcd,
                                                    input logic din);
        logic [4*DIGITS-1:0] adj;
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = adj[4*i +: 4];
            end
        end
        return {adj[4*DIGITS-2:0], din};
    endfunction

    logic [PW-1:0]        presc_r;
    logic [SW-1:0]        sec_cnt_r;
    logic [WIDTH-1:0]     step_index_r;
    logic                 req_r;
    logic                 sec_tick_s;

    job_state_t           job_state_r;
    logic                 pending_r;
    logic [WIDTH-1:0]     id_r;
    logic [WIDTH-1:0]     step_r;
    logic [WIDTH-1:0]     h_r;
    logic [RW-1:0]        round_r;
    logic [CW-1:0]        bit_cnt_r;
    logic [4*DIGITS-1:0]  bcd_r;
    logic [4*DIGITS-1:0]  code_r;

    logic                 sync1_r;
    logic                 sync2_r;
    logic                 deb_r;
    logic                 rise_r;
    logic [DW-1:0]        deb_cnt_r;

    disp_state_t          disp_state_r;
    logic [TW-1:0]        timer_r;

    logic                 commit_s;
    logic                 valid_nxt_s;
    logic [4*DIGITS-1:0]  code_nxt_s;

    assign sec_tick_s  = (presc_r == PW'(TICK_DIV - 1));
    assign commit_s    = (job_state_r == JOB_COMMIT);
    assign valid_nxt_s = commit_s | code_valid;
    assign code_nxt_s  = commit_s ? bcd_r : code_r;

    // Timebase; reset arms a request so step 0 is hashed right after release.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            presc_r      <= {PW{1'b0}};
            sec_cnt_r    <= {SW{1'b0}};
            step_index_r <= {WIDTH{1'b0}};
            req_r        <= 1'b1;
        end else begin
            req_r <= 1'b0;
            if (sec_tick_s) begin
                presc_r <= {PW{1'b0}};
                if (sec_cnt_r == SW'(STEP_SEC - 1)) begin
                    sec_cnt_r    <= {SW{1'b0}};
                    step_index_r <= step_index_r + WIDTH'(1);
                    req_r        <= 1'b1;
                end else begin
                    sec_cnt_r <= sec_cnt_r + SW'(1);
                end
            end else begin
                presc_r <= presc_r + PW'(1);
            end
        end
    end

    // Job FSM: hash rounds, serial BCD conversion, commit; busy requests merge into pending.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            job_state_r <= JOB_IDLE;
            pending_r   <= 1'b0;
            id_r        <= {WIDTH{1'b0}};
            step_r      <= {WIDTH{1'b0}};
            h_r         <= {WIDTH{1'b0}};
            round_r     <= {RW{1'b0}};
            bit_cnt_r   <= {CW{1'b0}};
            bcd_r       <= {(4*DIGITS){1'b0}};
            code_r      <= {(4*DIGITS){1'b0}};
            code_valid  <= 1'b0;
        end else begin
            if (req_r && (job_state_r != JOB_IDLE)) begin
                pending_r <= 1'b1;
            end
            case (job_state_r)
                JOB_IDLE: begin
                    if (req_r || pending_r) begin
                        id_r        <= student_id;
                        step_r      <= step_index_r;
                        h_r         <= student_id ^ step_index_r;
                        round_r     <= {RW{1'b0}};
                        pending_r   <= 1'b0;
                        job_state_r <= JOB_HASH;
                    end
                end
                JOB_HASH: begin
                    h_r <= hash_round(h_r, id_r, step_r, round_r);
                    if (round_r == RW'(ROUNDS - 1)) begin
                        bcd_r       <= {(4*DIGITS){1'b0}};
                        bit_cnt_r   <= {CW{1'b0}};
                        job_state_r <= JOB_CONVERT;
                    end else begin
                        round_r <= round_r + RW'(1);
                    end
                end
                JOB_CONVERT: begin
                    bcd_r <= dabble(bcd_r, h_r[WIDTH-1]);
                    h_r   <= {h_r[WIDTH-2:0], 1'b0};
                    if (bit_cnt_r == CW'(WIDTH - 1)) begin
                        job_state_r <= JOB_COMMIT;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CW'(1);
                    end
                end
                JOB_COMMIT: begin
                    code_r      <= bcd_r;
                    code_valid  <= 1'b1;
                    job_state_r <= JOB_IDLE;
                end
                default: begin
                    job_state_r <= JOB_IDLE;
                end
            endcase
        end
    end

    // Button synchroniser and debouncer; rise_r marks an accepted rising edge.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            deb_r     <= 1'b0;
            rise_r    <= 1'b0;
            deb_cnt_r <= {DW{1'b0}};
        end else begin
            sync1_r <= button_in;
            sync2_r <= sync1_r;
            rise_r  <= 1'b0;
            if (sync2_r == deb_r) begin
                deb_cnt_r <= {DW{1'b0}};
            end else if (deb_cnt_r == DW'(DEBOUNCE - 1)) begin
                deb_r     <= sync2_r;
                deb_cnt_r <= {DW{1'b0}};
                rise_r    <= sync2_r;
            end else begin
                deb_cnt_r <= deb_cnt_r + DW'(1);
            end
        end
    end

    // Display window FSM; outputs use next-cycle code so a commit shows immediately.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            disp_state_r <= DISP_OFF;
            timer_r      <= {TW{1'b0}};
            display_on   <= 1'b0;
            digits_out   <= BLANK;
        end else begin
            case (disp_state_r)
                DISP_OFF: begin
                    if (rise_r) begin
                        disp_state_r <= DISP_ON;
                        timer_r      <= TW'(SHOW_SEC);
                        display_on   <= valid_nxt_s;
                        digits_out   <= valid_nxt_s ? code_nxt_s : BLANK;
                    end else begin
                        display_on <= 1'b0;
                        digits_out <= BLANK;
                    end
                end
                DISP_ON: begin
                    if (rise_r || (sec_tick_s && (timer_r == TW'(1)))) begin
                        disp_state_r <= DISP_OFF;
                        timer_r      <= {TW{1'b0}};
                        display_on   <= 1'b0;
                        digits_out   <= BLANK;
                    end else begin
                        if (sec_tick_s) begin
                            timer_r <= timer_r - TW'(1);
                        end
                        display_on <= valid_nxt_s;
                        digits_out <= valid_nxt_s ? code_nxt_s : BLANK;
                    end
                end
                default: begin
                    disp_state_r <= DISP_OFF;
                    timer_r      <= {TW{1'b0}};
                    display_on   <= 1'b0;
                    digits_out   <= BLANK;
                end
            endcase
        end
    end

endmodule
